// File: rtl/rxecrc.sv
// rxecrc: receive-path Ethernet FCS checker and stripper.
module rxecrc #(
  parameter int NFCS = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_cancel,
  input  logic       i_v,
  input  logic [3:0] i_d,
  output logic       o_v,
  output logic [3:0] o_d,
  output logic       o_err
);
  typedef enum logic [2:0] {IDLE, FILL, RUN, BYPASS, WAIT} state_t;
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] RES = 32'hDEBB20E3;
  localparam logic [3:0] NF = 4'(NFCS);
  state_t state, state_n;
  logic [31:0] crc, crc_n;
  logic [4*NFCS-1:0] dl;
  logic [3:0] fill, o_d_n;
  logic o_v_n, o_err_n, start, bad, chk;
  function automatic logic [31:0] crc4(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction
  assign start = i_v && !i_cancel;
  assign chk = state == FILL || state == RUN;
  assign bad = (crc != RES) || (fill < NF);
  // a frame's first nibble is absorbed straight into a freshly seeded CRC
  assign crc_n = crc4(state == IDLE ? 32'hFFFFFFFF : crc, i_d);
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      crc   <= '1;
      fill  <= '0;
      dl    <= '0;
      o_v   <= 1'b0;
      o_d   <= '0;
      o_err <= 1'b0;
    end else if (i_ce) begin
      state <= state_n;
      o_v   <= o_v_n;
      o_d   <= o_d_n;
      o_err <= o_err_n;
      if (i_v) dl <= {dl[4*NFCS-5:0], i_d};
      crc  <= state == IDLE ? (start ? crc_n : '1) : (chk && i_v) ? crc_n : crc;
      fill <= state == IDLE ? {3'b0, start} : (chk && i_v && fill != NF) ? fill + 4'd1 : fill;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (i_en ? FILL : BYPASS) : IDLE;
      FILL:    state_n = i_cancel ? WAIT : !i_v ? IDLE : (fill == NF - 4'd1) ? RUN : FILL;
      RUN:     state_n = i_cancel ? WAIT : i_v ? RUN : IDLE;
      BYPASS:  state_n = i_cancel ? WAIT : i_v ? BYPASS : IDLE;
      WAIT:    state_n = i_v ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_v_n   = 1'b0;
    o_d_n   = o_d;
    o_err_n = o_err;
    case (state)
      IDLE: begin
        o_v_n   = start && !i_en;
        o_d_n   = (start && !i_en) ? i_d : o_d;
        o_err_n = (i_v || i_cancel) ? 1'b0 : o_err;
      end
      FILL, RUN: begin
        o_v_n   = state == RUN && i_v && !i_cancel;
        o_d_n   = (state == RUN && i_v && !i_cancel) ? dl[4*NFCS-1 -: 4] : o_d;
        o_err_n = i_cancel ? 1'b0 : !i_v ? bad : o_err;
      end
      BYPASS: begin
        o_v_n   = i_v && !i_cancel;
        o_d_n   = i_d;
        o_err_n = 1'b0;
      end
      default: o_err_n = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_rxecrc.sv
// tb_rxecrc: directed frames for rxecrc, checked by a queue-fed monitor.
module tb_rxecrc;
  logic i_clk = 0, i_reset_n = 0, i_ce = 0, i_en = 0, i_cancel = 0, i_v = 0;
  logic [3:0] i_d = 0;
  logic o_v, o_err;
  logic [3:0] o_d;
  typedef struct packed {logic v0; logic d0; logic err;} chk_t;
  logic [3:0] exp_d[$];
  chk_t exp_c[$];
  logic chk = 0;
  int n_vec = 0, n_bad = 0;
  // "123456789" then FCS 26 39 F4 CB, low nibble first
  logic [3:0] good[26] = '{4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5, 4'h3, 4'h6, 4'h3, 4'h7,
                           4'h3, 4'h8, 4'h3, 4'h9, 4'h3, 4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};

  rxecrc dut (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_en(i_en), .i_cancel(i_cancel),
              .i_v(i_v), .i_d(i_d), .o_v(o_v), .o_d(o_d), .o_err(o_err));

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    logic ce_s, rn_s, c_s;
    chk_t e;
    logic [3:0] x;
    ce_s = i_ce;
    rn_s = i_reset_n;
    c_s = chk;
    #1;
    if (c_s && exp_c.size() != 0) begin
      e = exp_c.pop_front();
      n_vec++;
      if ((e.v0 && o_v) || (e.d0 && o_d != 4'h0) || o_err != e.err) begin
        n_bad++;
        $display("FAIL status @%0t: o_v=%0b o_d=%h o_err=%0b, required err=%0b (o_v must be 0: %0b, o_d must be 0: %0b)",
                 $time, o_v, o_d, o_err, e.err, e.v0, e.d0);
      end
    end
    if (ce_s && rn_s && o_v) begin
      n_vec++;
      if (exp_d.size() == 0) begin
        n_bad++;
        $display("FAIL extra_nibble @%0t: o_d=%h with none expected", $time, o_d);
      end else begin
        x = exp_d.pop_front();
        if (o_d != x) begin
          n_bad++;
          $display("FAIL nibble @%0t: o_d=%h required %h", $time, o_d, x);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [3:0] d, input logic ce);
    @(negedge i_clk);
    i_reset_n = 1;
    chk = 0;
    i_cancel = 0;
    i_v = v;
    i_d = d;
    i_ce = ce;
  endtask

  task automatic mark(input logic v0, input logic d0, input logic err);
    chk = 1;
    exp_c.push_back({v0, d0, err});
  endtask

  task automatic frame(input int n, input logic en, input int per, input int cancel_at,
                       input int flip_at, input int reset_at, input logic exp_err);
    logic [3:0] d;
    for (int k = 0; k < n; k++) begin
      d = good[k] ^ ((k == flip_at) ? 4'hF : 4'h0);
      for (int p = 0; p < per; p++) begin
        cyc(1, d, p == per - 1);
        i_en = (k >= 10) ? 1'b1 : en;
      end
      if (k == 0) mark(en, 0, 0);
      if (k == reset_at) begin
        i_reset_n = 0;
        mark(1, 1, 0);
        break;
      end
      if (k == cancel_at) begin
        i_cancel = 1;
        mark(1, 0, 0);
      end else if (cancel_at < 0 || k < cancel_at) begin
        if (!en) exp_d.push_back(d);
        else if (k >= 8) exp_d.push_back(good[k-8] ^ ((k - 8 == flip_at) ? 4'hF : 4'h0));
      end
    end
    cyc(0, 0, 1);
    mark(1, 0, exp_err);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    mark(1, 0, exp_err);
    cyc(0, 0, 1);
  endtask

  initial begin
    cyc(0, 0, 0);
    i_reset_n = 0;
    mark(1, 1, 0);
    cyc(0, 0, 1);
    frame(26, 1, 1, -1, -1, -1, 0);
    frame(26, 1, 1, -1, 5, -1, 1);
    frame(6, 1, 1, -1, -1, -1, 1);
    frame(8, 1, 1, -1, -1, -1, 1);
    frame(26, 1, 1, 12, -1, -1, 0);
    frame(26, 1, 1, -1, -1, -1, 0);
    frame(26, 0, 1, -1, -1, -1, 0);
    frame(26, 1, 4, -1, -1, -1, 0);
    frame(26, 1, 1, -1, 5, -1, 1);
    frame(26, 1, 1, -1, -1, 14, 0);
    frame(26, 1, 1, -1, -1, -1, 0);
    repeat (4) cyc(0, 0, 1);
    n_vec++;
    if (exp_d.size() != 0 || exp_c.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d nibbles and %0d status checks left, required 0 and 0", exp_d.size(), exp_c.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rxecrc.md
# rxecrc

Receive-path Ethernet FCS checker and stripper. It sits between preamble removal and minimum-length enforcement, and consumes the per-nibble receive stream (`i_v`/`i_d`, low nibble of each byte first). It computes the IEEE 802.3 CRC-32 over every nibble of the frame and removes the trailing 8 FCS nibbles from the output stream. At end of frame it flags `o_err` if the CRC residue is wrong or the frame is too short to contain an FCS.

## Interface
- `NFCS`, default 8: FCS length in nibbles to strip; must be 8 for Ethernet.
- `i_clk`, input, 1: system clock; all logic is on the rising edge.
- `i_reset_n`, input, 1: synchronous, active-low reset; takes effect regardless of `i_ce`.
- `i_ce`, input, 1: nibble-rate clock enable; all non-reset state changes only on `i_ce` cycles.
- `i_en`, input, 1: CRC check and strip enable; sampled only at frame start.
- `i_cancel`, input, 1: abort the current frame; sampled on `i_ce` cycles.
- `i_v`, input, 1: input nibble valid; high for the whole frame.
- `i_d`, input, 4: input data nibble, bit 0 first on the wire.
- `o_v`, output, 1: output nibble valid.
- `o_d`, output, 4: output data nibble.
- `o_err`, output, 1: CRC/length error for the frame just ended.

## Operation
- CRC arithmetic:
  - 32-bit reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - 4 bits per `i_ce && i_v` cycle, processed `i_d[0]` first.
  - Good-frame residue after absorbing data plus FCS is 0xDEBB20E3.
  - The CRC register is reloaded with 0xFFFFFFFF in IDLE.
- Delay line:
  - 8-entry, 4-bit shift register.
  - A 4-bit fill counter saturates at `NFCS`.
  - Both advance only on `i_ce && i_v`.
- States:
  - **IDLE**
    - On `i_ce && i_v && !i_cancel`: go to FILL if `i_en`, else go to BYPASS.
    - The first nibble is absorbed into the CRC and the delay line in the same cycle.
  - **FILL**
    - Shift in nibbles, `o_v` = 0.
    - When the fill count reaches 8 with `i_v` still high, go to RUN.
  - **RUN**
    - Each `i_ce && i_v`: `o_v` <= 1 and `o_d` <= oldest delay entry, while the new nibble is shifted in.
  - **BYPASS**
    - `o_v` <= `i_v`, `o_d` <= `i_d` on each `i_ce`.
    - No CRC check, `o_err` stays 0.
    - Return to IDLE on `!i_v`.
  - **End of frame** (FILL or RUN with `i_ce && !i_v`):
    - `o_v` <= 0.
    - `o_err` <= (crc != 0xDEBB20E3) || (fill < 8).
    - Go to IDLE.
  - **WAIT**
    - Entered on `i_cancel` from any non-IDLE state.
    - `o_v` <= 0, `o_err` <= 0.
    - Stay until `i_ce && !i_v`, then go to IDLE.
    - Nibbles arriving in WAIT are discarded.
- `o_err` lifetime:
  - Set at end of frame.
  - Held through IDLE until the next frame's first nibble, a cancel, or reset clears it.
- `i_cancel` in IDLE: `o_err` <= 0, state stays IDLE.
- Simultaneous `i_cancel` and end of frame: cancel wins; `o_err` = 0.
- Reset values:
  - `o_v` = 0, `o_d` = 0, `o_err` = 0.
  - State = IDLE, fill count = 0, CRC = 0xFFFFFFFF.
- Reset mid-frame: the rest of the frame is treated as a new frame starting at the next `i_v` nibble. Upstream should cancel or gap the stream.
- A change of `i_en` mid-frame has no effect until the next IDLE.

## Timing
- Outputs are registered and update only on `i_ce` cycles; between them they hold their value.
- Checked mode:
  - Input nibble k appears on `o_d` on the `i_ce` cycle that accepts input nibble k+8, registered one clock after it.
  - Total nibbles out = nibbles in − 8.
- Bypass mode: 1 `i_ce` cycle latency, no nibble removed.
- `o_err` is valid one clock after the `i_ce` cycle on which `i_v` first drops. That same edge deasserts `o_v`.
- Back-to-back frames need at least one `i_ce` cycle with `i_v` = 0 between them.

## Test plan
- **Good frame:** ASCII "123456789" followed by FCS bytes 26 39 F4 CB, as 26 nibbles (1,3,2,3,…,6,2,9,3,4,F,B,C), `i_en` = 1, `i_ce` = 1 → 18 output nibbles equal the first 18 inputs in order, `o_v` high for exactly 18 cycles, `o_err` = 0.
- **Bad CRC:** the same frame with nibble 5 inverted (0x3 → 0xC) → 18 nibbles out, `o_err` = 1 after `i_v` falls, held until the next frame starts.
- **Short frame:** 6 nibbles → `o_v` never asserts, `o_err` = 1. A 0-gap frame of 8 nibbles → no output, `o_err` = 1 (residue mismatch).
- **Cancel mid-frame:** assert `i_cancel` at nibble 12 of the good frame → `o_v` drops the next clock, `o_err` = 0, remaining nibbles are dropped. The following good frame passes cleanly.
- **Bypass:** `i_en` = 0 at frame start → all 26 nibbles out with 1-cycle latency, `o_err` = 0. Toggling `i_en` to 1 mid-frame changes nothing.
- **Reset and `i_ce`:** `i_ce` high one clock in four during the good frame → identical nibble sequence out and `o_err` = 0. Pulling `i_reset_n` low mid-frame forces `o_v`, `o_d` and `o_err` to 0 on the next clock.
